// File: rtl/clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clock_switch_ctrl
//
// Control FSM for a glitch-free two-source clock switch. It decides which
// source (clk_a or clk_b) the downstream switch should use and paces changes
// so the switch has time to settle and cannot be toggled too quickly.
//
// A request is settled in one of three ways:
//   - same source already selected -> done pulse, nothing changes
//   - target source dead           -> err pulse, nothing changes
//   - target source alive          -> select flips, SETTLE, then HOLD
// With AUTO_FAILOVER set, losing the current source while the other one is
// alive forces a switch-away (fail_event) from IDLE or HOLD.
//
// Handshake: a request transfers on a clk edge where req_valid && req_ready.
// req_valid may be held high; req_ready is a combinational function of the
// current state and the ok inputs and never depends on req_valid.
//
// Ports
//   clk, rst        reference clock, synchronous active-high reset
//   req_valid       switch request
//   req_sel         requested source (0 = clk_a, 1 = clk_b)
//   req_ready       request can be accepted this cycle (combinational)
//   clk_a_ok        clk_a alive (already synchronised to clk)
//   clk_b_ok        clk_b alive (already synchronised to clk)
//   select          registered source select for the clock switch
//   busy            registered, high while in SETTLE or HOLD
//   done            one-cycle pulse: requested source is in effect
//   err             one-cycle pulse: request rejected
//   fail_event      one-cycle pulse: automatic failover started
//   dbg_state       current FSM state (0 = IDLE, 1 = SETTLE, 2 = HOLD)
// -----------------------------------------------------------------------------
module clock_switch_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter int HOLD_CYCLES   = 64,
   parameter int CNT_W         = 8,
   parameter bit AUTO_FAILOVER = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_sel,
   output logic       req_ready,
   input  logic       clk_a_ok,
   input  logic       clk_b_ok,
   output logic       select,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       fail_event,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Counter reload values; the counter counts down to zero inclusive, so a
   // phase of N cycles starts at N-1.
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

   state_t           state_q, state_d;
   logic             select_q, select_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             fail_q, fail_d;

   logic ok_cur;
   logic ok_other;
   logic fail_cond;

   // Health of the currently selected source and of the alternative.
   assign ok_cur    = select_q ? clk_b_ok : clk_a_ok;
   assign ok_other  = select_q ? clk_a_ok : clk_b_ok;
   // With both sources dead there is nowhere better to go, so no failover.
   assign fail_cond = AUTO_FAILOVER && !ok_cur && ok_other;

   // Failover outranks a request, so a pending request is held off while
   // fail_cond is true; reset also blocks acceptance.
   assign req_ready = !rst && (state_q == ST_IDLE) && !fail_cond;

   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      fail_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fail_cond) begin
               select_d = !select_q;
               fail_d   = 1'b1;
               cnt_d    = SETTLE_LOAD;
               state_d  = ST_SETTLE;
            end else if (req_valid) begin
               if (req_sel == select_q) begin
                  done_d = 1'b1;
               end else if (ok_other) begin
                  // req_sel differs from select, so the target is the other source.
                  select_d = req_sel;
                  cnt_d    = SETTLE_LOAD;
                  state_d  = ST_SETTLE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_SETTLE: begin
            // Requests and source health are deliberately ignored here: the
            // switch is mid-transition and must be allowed to finish.
            if (cnt_q == CNT_ZERO) begin
               done_d  = 1'b1;
               cnt_d   = HOLD_LOAD;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_HOLD: begin
            // A dead source cuts the dwell short.
            if (fail_cond) begin
               select_d = !select_q;
               fail_d   = 1'b1;
               cnt_d    = SETTLE_LOAD;
               state_d  = ST_SETTLE;
            end else if (cnt_q == CNT_ZERO) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         select_q <= 1'b0;
         cnt_q    <= CNT_ZERO;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
      end
   end

   assign select     = select_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign fail_event = fail_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_switch_ctrl
//
// Bench for clock_switch_ctrl with SETTLE_CYCLES=4, HOLD_CYCLES=8.
// The reference model tracks only the selected source and two absolute cycle
// stamps: when the pending done pulse is due and when the block is next idle.
// -----------------------------------------------------------------------------
module tb_clock_switch_ctrl;

   localparam int S = 4;
   localparam int H = 8;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_sel;
   logic       req_ready;
   logic       clk_a_ok;
   logic       clk_b_ok;
   logic       select;
   logic       busy;
   logic       done;
   logic       err;
   logic       fail_event;
   logic [1:0] dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   clock_switch_ctrl #(
      .SETTLE_CYCLES(S),
      .HOLD_CYCLES  (H),
      .CNT_W        (8),
      .AUTO_FAILOVER(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .clk_a_ok  (clk_a_ok),
      .clk_b_ok  (clk_b_ok),
      .select    (select),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .fail_event(fail_event),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int   cyc       = 0;
   int   m_idle_at = 0;   // first cycle the block is idle again
   int   m_done_at = -1;  // cycle in which the settle done pulse is visible
   logic m_sel     = 1'b0;

   // Observations from the last step, for directed checks.
   logic obs_ready, obs_sel, obs_busy, obs_done, obs_err, obs_fail;

   task automatic start_switch();
      m_done_at = cyc + 1 + S;
      m_idle_at = cyc + 1 + S + H;
   endtask

   // One clock cycle: apply inputs just after a falling edge, check the
   // combinational ready, advance the model, then check registered outputs
   // at the next falling edge.
   task automatic step(input logic r, input logic rv, input logic rs,
                       input logic ao, input logic bo);
      logic idle, hold, okc, oko, fc;
      logic e_ready, e_done, e_err, e_fail, e_busy;
      rst       = r;
      req_valid = rv;
      req_sel   = rs;
      clk_a_ok  = ao;
      clk_b_ok  = bo;
      #1;
      idle    = (cyc >= m_idle_at);
      hold    = !idle && (cyc >= m_done_at);
      okc     = m_sel ? bo : ao;
      oko     = m_sel ? ao : bo;
      fc      = !okc && oko;
      e_ready = !r && idle && !fc;
      chk("req_ready", req_ready, e_ready);
      obs_ready = req_ready;

      e_done = (cyc + 1 == m_done_at);
      e_err  = 1'b0;
      e_fail = 1'b0;
      if (r) begin
         m_sel     = 1'b0;
         m_idle_at = cyc + 1;
         m_done_at = -1;
         e_done    = 1'b0;
      end else if ((idle || hold) && fc) begin
         m_sel  = !m_sel;
         e_fail = 1'b1;
         start_switch();
      end else if (idle && rv) begin
         if (rs == m_sel) e_done = 1'b1;
         else if (oko) begin
            m_sel = rs;
            start_switch();
         end else e_err = 1'b1;
      end
      cyc++;
      e_busy = (cyc < m_idle_at);

      @(posedge clk);
      @(negedge clk);
      chk("select", select, m_sel);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("fail_event", fail_event, e_fail);
      obs_sel  = select;
      obs_busy = busy;
      obs_done = done;
      obs_err  = err;
      obs_fail = fail_event;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic r, rv, rs, ao, bo;
      logic x_ready, x_sel, x_busy, x_done, x_err;
   } vec_t;

   vec_t tbl[17];

   function automatic vec_t mk(logic r, logic rv, logic rs, logic ao, logic bo,
                               logic x_ready, logic x_sel, logic x_busy,
                               logic x_done, logic x_err);
      vec_t v;
      v.r = r; v.rv = rv; v.rs = rs; v.ao = ao; v.bo = bo;
      v.x_ready = x_ready; v.x_sel = x_sel; v.x_busy = x_busy;
      v.x_done = x_done; v.x_err = x_err;
      return v;
   endfunction

   initial begin
      int n;
      rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0;
      clk_a_ok = 1'b1; clk_b_ok = 1'b1;

      // x_ready is checked in the row's own cycle, the rest one edge later.
      tbl[0] = mk(1, 0, 0, 1, 1,  0, 0, 0, 0, 0);   // reset
      tbl[1] = mk(0, 1, 0, 1, 1,  1, 0, 0, 1, 0);   // same source -> done
      tbl[2] = mk(0, 1, 1, 1, 0,  1, 0, 0, 0, 1);   // dead target -> err
      tbl[3] = mk(0, 1, 1, 1, 1,  1, 1, 1, 0, 0);   // switch to clk_b
      for (int i = 4; i < 8; i++)                    // settle, done on last
         tbl[i] = mk(0, 1, 0, 1, 1,  0, 1, 1, (i == 7), 0);
      for (int i = 8; i < 16; i++)                   // hold dwell
         tbl[i] = mk(0, 1, 0, 1, 1,  0, 1, (i != 15), 0, 0);
      tbl[16] = mk(0, 0, 0, 1, 1,  1, 1, 0, 0, 0);  // idle again

      @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].r, tbl[i].rv, tbl[i].rs, tbl[i].ao, tbl[i].bo);
         chk($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].x_ready);
         chk($sformatf("tbl%0d_select", i), obs_sel, tbl[i].x_sel);
         chk($sformatf("tbl%0d_busy", i), obs_busy, tbl[i].x_busy);
         chk($sformatf("tbl%0d_done", i), obs_done, tbl[i].x_done);
         chk($sformatf("tbl%0d_err", i), obs_err, tbl[i].x_err);
      end

      // ---- failover from HOLD at counter 5 (select=1) ----
      step(0, 1, 0, 1, 1);                         // switch back to clk_a
      for (int i = 0; i < S + H; i++) step(0, 0, 0, 1, 1);
      step(0, 1, 1, 1, 1);                         // switch to clk_b
      for (int i = 0; i < S; i++) step(0, 0, 0, 1, 1);
      chk("fo_done_before_hold", obs_done, 1'b1);
      step(0, 0, 0, 1, 1);                         // hold counter 7 -> 6
      step(0, 0, 0, 1, 1);                         // now at counter 5
      step(0, 0, 0, 1, 0);                         // clk_b dies
      chk("fo_fail_event", obs_fail, 1'b1);
      chk("fo_select", obs_sel, 1'b0);
      chk("fo_busy", obs_busy, 1'b1);
      for (int i = 0; i < S; i++) begin
         step(0, 0, 0, 1, 0);
         chk($sformatf("fo_done_at_%0d", i + 1), obs_done, (i == S - 1));
      end
      for (int i = 0; i < H; i++) step(0, 0, 0, 1, 1);

      // ---- failover priority over a request in IDLE ----
      // select=0 here; clk_a dies while a request for clk_a is held.
      step(0, 1, 0, 0, 1);
      chk("pri_ready_low", obs_ready, 1'b0);
      chk("pri_fail_event", obs_fail, 1'b1);
      chk("pri_select", obs_sel, 1'b1);
      n = 0;
      while (n < 40) begin
         step(0, 1, 0, 1, 1);
         if (obs_ready) break;
         n++;
      end
      chk("pri_wait_timeout", (n < 40), 1'b1);
      chk("pri_wait_len", (n == S + H), 1'b1);
      chk("pri_accept_select", obs_sel, 1'b0);
      for (int i = 0; i < S + H; i++) step(0, 0, 0, 1, 1);

      // ---- reset in SETTLE at counter 2 with select=1 ----
      step(0, 1, 1, 1, 1);
      step(0, 0, 0, 1, 1);                         // counter 3 -> 2
      step(1, 1, 1, 1, 1);                         // reset at counter 2
      chk("rst_select", obs_sel, 1'b0);
      chk("rst_busy", obs_busy, 1'b0);
      chk("rst_ready_low", obs_ready, 1'b0);
      for (int i = 0; i < S + 2; i++) begin
         step(0, 0, 0, 1, 1);
         chk("rst_no_done", obs_done, 1'b0);
      end
      step(0, 1, 1, 1, 1);
      chk("rst_first_accept", obs_ready, 1'b1);
      for (int i = 0; i < S + H; i++) step(0, 0, 0, 1, 1);

      // ---- both sources dead: nothing happens ----
      step(0, 1, 0, 0, 0);
      chk("dead_no_fail", obs_fail, 1'b0);
      chk("dead_err", obs_err, 1'b1);
      chk("dead_select", obs_sel, 1'b1);

      // ---- randomised traffic against the model ----
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 7) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
